// File: rtl/logic_unit_pipe_if.sv
// Valid/ready bus for the pipelined logic unit: producer side (in_*, operands)
// and consumer side (out_*, result and flags).
interface logic_unit_pipe_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;

    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, parity
    );

    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with an accumulate mode.
// Zero and parity flags travel with the result.
module logic_unit_pipe #(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    logic_unit_pipe_if.slave bus
);
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_res;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] y_r;
    logic             zero_r;
    logic             parity_r;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res;

    always_comb begin
        s2_adv = !s2_valid || bus.out_ready;
        s1_adv = !s1_valid || s2_adv;
        accept = bus.in_valid && s1_adv;
    end

    // A clear in the same cycle as an accumulate op makes that op see zero.
    always_comb begin
        a_eff = bus.a;
        if (bus.op[3]) a_eff = bus.acc_clr ? '0 : acc;
        case (bus.op[2:0])
            3'd0:    res = a_eff & bus.b;
            3'd1:    res = a_eff | bus.b;
            3'd2:    res = a_eff ^ bus.b;
            3'd3:    res = ~(a_eff & bus.b);
            3'd4:    res = ~(a_eff | bus.b);
            3'd5:    res = ~(a_eff ^ bus.b);
            3'd6:    res = ~a_eff;
            default: res = a_eff;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) s1_res <= res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y_r      <= '0;
            zero_r   <= 1'b0;
            parity_r <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y_r      <= s1_res;
                zero_r   <= (s1_res == '0);
                parity_r <= ^s1_res;
            end
        end
    end

    // Updated at accept so back-to-back accumulate ops chain without waiting on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && bus.op[3]) begin
            acc <= res;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.y         = y_r;
    assign bus.zero      = zero_r;
    assign bus.parity    = parity_r;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed tests on a 4-bit instance,
// random stream on a 16-bit instance.
module tb_logic_unit_pipe;
    typedef struct {
        logic [15:0] y;
        logic        z;
        logic        p;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.WIDTH(4))  if4 ();
    logic_unit_pipe_if #(.WIDTH(16)) if16 ();

    logic_unit_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    logic_unit_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    logic        sel16;
    logic        drv_valid;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic [3:0]  drv_op;
    logic        drv_clr;
    logic        drv_ordy;

    assign if4.in_valid   = !sel16 && drv_valid;
    assign if4.a          = drv_a[3:0];
    assign if4.b          = drv_b[3:0];
    assign if4.op         = drv_op;
    assign if4.acc_clr    = !sel16 && drv_clr;
    assign if4.out_ready  = sel16 ? 1'b1 : drv_ordy;
    assign if16.in_valid  = sel16 && drv_valid;
    assign if16.a         = drv_a;
    assign if16.b         = drv_b;
    assign if16.op        = drv_op;
    assign if16.acc_clr   = sel16 && drv_clr;
    assign if16.out_ready = sel16 ? drv_ordy : 1'b1;

    logic        obs_ready;
    logic        obs_valid;
    logic [15:0] obs_y;
    logic        obs_zero;
    logic        obs_parity;

    assign obs_ready  = sel16 ? if16.in_ready  : if4.in_ready;
    assign obs_valid  = sel16 ? if16.out_valid : if4.out_valid;
    assign obs_y      = sel16 ? if16.y         : {12'b0, if4.y};
    assign obs_zero   = sel16 ? if16.zero      : if4.zero;
    assign obs_parity = sel16 ? if16.parity    : if4.parity;

    int          n_chk;
    int          n_err;
    int          cyc;
    int          n_acc;
    logic        last_acc;
    logic        lat_mode;
    logic        rnd_ordy;
    logic [15:0] m_acc;
    exp_t        q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lu_model(input logic [2:0] f, input logic [15:0] x,
                                             input logic [15:0] y, input logic [15:0] mask);
        logic [15:0] r;
        case (f)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        return r & mask;
    endfunction

    // One clock: check outputs and the input handshake at the falling edge,
    // update the model, then advance past the next rising edge.
    task automatic step(input logic use_tab, input logic [15:0] tab_y);
        logic [15:0] mask;
        logic [15:0] a_eff;
        logic [15:0] res;
        exp_t        e;
        mask = sel16 ? 16'hFFFF : 16'h000F;
        @(negedge clk);
        chk("in_ready", {31'b0, obs_ready}, {31'b0, !(q.size() == 2 && !drv_ordy)});
        if (q.size() == 0) chk("spurious_out", {31'b0, obs_valid}, 32'd0);
        if (obs_valid && q.size() != 0) begin
            e = q[0];
            chk("y", {16'b0, obs_y}, {16'b0, e.y});
            chk("zero", {31'b0, obs_zero}, {31'b0, e.z});
            chk("parity", {31'b0, obs_parity}, {31'b0, e.p});
            if (drv_ordy) begin
                if (lat_mode) chk("latency", cyc - e.cyc, 32'd2);
                void'(q.pop_front());
            end
        end
        last_acc = drv_valid && obs_ready;
        a_eff = drv_op[3] ? (drv_clr ? 16'h0 : m_acc) : (drv_a & mask);
        if (last_acc) begin
            res = use_tab ? tab_y : lu_model(drv_op[2:0], a_eff, drv_b & mask, mask);
            e.y = res;
            e.z = (res == 16'h0);
            e.p = ^res;
            e.cyc = cyc;
            q.push_back(e);
            n_acc++;
            if (drv_op[3]) m_acc = lu_model(drv_op[2:0], a_eff, drv_b & mask, mask);
            else if (drv_clr) m_acc = 16'h0;
        end else if (drv_clr) begin
            m_acc = 16'h0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rnd_ordy) drv_ordy = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic clr, input logic use_tab, input logic [15:0] tab_y);
        int n;
        drv_valid = 1'b1;
        drv_a = a;
        drv_b = b;
        drv_op = op;
        drv_clr = clr;
        n = 0;
        do begin
            step(use_tab, tab_y);
            drv_clr = 1'b0;
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", n, 32'd0);
        drv_valid = 1'b0;
    endtask

    task automatic drain();
        drv_valid = 1'b0;
        rnd_ordy = 1'b0;
        drv_ordy = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0);
        chk("drain_empty", q.size(), 32'd0);
    endtask

    logic [3:0] tab_ops [8];

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; n_acc = 0;
        last_acc = 1'b0; lat_mode = 1'b0; rnd_ordy = 1'b0; m_acc = 16'h0;
        sel16 = 1'b0; drv_valid = 1'b0; drv_a = 16'h0; drv_b = 16'h0;
        drv_op = 4'h0; drv_clr = 1'b0; drv_ordy = 1'b1;
        tab_ops = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'h1, 4'hE};
        rst_n = 1'b0;
        #3;
        chk("rst_out_valid", {31'b0, obs_valid}, 32'd0);
        chk("rst_y", {16'b0, obs_y}, 32'd0);
        chk("rst_zero", {31'b0, obs_zero}, 32'd0);
        chk("rst_parity", {31'b0, obs_parity}, 32'd0);
        chk("rst_in_ready", {31'b0, obs_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Every op over a=1110 b=1000 with fixed expected results.
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++)
            send(16'hE, 16'h8, 4'(i), 1'b0, 1'b1, {12'b0, tab_ops[i]});
        drain();

        // Accumulate chain.
        drv_clr = 1'b1;
        step(1'b0, 16'h0);
        drv_clr = 1'b0;
        send(16'h5, 16'hA, 4'h9, 1'b0, 1'b1, 16'hA);
        send(16'h5, 16'h6, 4'hA, 1'b0, 1'b1, 16'hC);
        send(16'h5, 16'hF, 4'hE, 1'b0, 1'b1, 16'h3);
        drain();

        // Clear colliding with an accumulate op.
        send(16'h0, 16'h0, 4'hE, 1'b1, 1'b1, 16'hF);
        send(16'h5, 16'hF, 4'h8, 1'b1, 1'b1, 16'h0);
        send(16'h5, 16'hF, 4'hF, 1'b0, 1'b1, 16'h0);
        drain();

        // Backpressure with random consumer.
        lat_mode = 1'b0;
        rnd_ordy = 1'b1;
        for (int i = 0; i < 6; i++)
            send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 16'h0);
        drain();

        // Reset in the middle of a stalled stream.
        drv_ordy = 1'b0;
        send(16'h3, 16'h5, 4'h2, 1'b0, 1'b0, 16'h0);
        send(16'h9, 16'h6, 4'h1, 1'b0, 1'b0, 16'h0);
        drv_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", {31'b0, obs_valid}, 32'd0);
        chk("midrst_y", {16'b0, obs_y}, 32'd0);
        chk("midrst_zero", {31'b0, obs_zero}, 32'd0);
        chk("midrst_parity", {31'b0, obs_parity}, 32'd0);
        chk("midrst_in_ready", {31'b0, obs_ready}, 32'd1);
        q.delete();
        m_acc = 16'h0;
        drv_valid = 1'b0;
        drv_ordy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat_mode = 1'b1;
        send(16'hC, 16'hA, 4'h5, 1'b0, 1'b0, 16'h0);
        drain();

        // Random stream on the 16-bit instance.
        sel16 = 1'b1;
        m_acc = 16'h0;
        lat_mode = 1'b0;
        n_acc = 0;
        begin
            int budget;
            budget = 0;
            while (n_acc < 1000 && budget < 20000) begin
                drv_valid = 1'($urandom_range(0, 3) != 0);
                drv_a = 16'($urandom);
                drv_b = 16'($urandom);
                drv_op = 4'($urandom_range(0, 15));
                drv_clr = ($urandom_range(0, 15) == 0);
                drv_ordy = 1'($urandom_range(0, 3) != 0);
                step(1'b0, 16'h0);
                budget++;
            end
            drv_clr = 1'b0;
            chk("rand_accepts", n_acc, 32'd1000);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
